// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: one core access at a time over a valid/ready memory port, with byte-lane
// steering, load extension and a response timeout. Define YSYX_23060111_LSU_MISALIGN_TRAP_EN to trap misaligned H/W/D.
module ysyx_23060111_lsu #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_wen,
  input  logic [2:0]          in_funct3,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_rdata,
  output logic                out_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned CntW  = 16;
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]  wmask_q, wmask_d;
  logic [OffW-1:0]   off_q, off_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [OffW-1:0]   in_off, size_mask, lane_off;
  logic [StrbW-1:0]  base_mask, st_mask;
  logic [DATA_W-1:0] base_wdata, st_wdata;
  logic              illegal, trap, timeout_hit;
  logic [DATA_W-1:0] shifted, ld_data;
`ifdef YSYX_23060111_LSU_MISALIGN_TRAP_EN
  logic              misaligned;
`endif

  // Request decode: size, lane offset (aligned down to the access size), store steering.
  always_comb begin
    in_off = in_addr[OffW-1:0];
    case (in_funct3[1:0])
      2'd0: begin
        size_mask  = '0;
        base_mask  = StrbW'(8'h01);
        base_wdata = DATA_W'(in_wdata[7:0]);
      end
      2'd1: begin
        size_mask  = OffW'(1);
        base_mask  = StrbW'(8'h03);
        base_wdata = DATA_W'(in_wdata[15:0]);
      end
      2'd2: begin
        size_mask  = OffW'(3);
        base_mask  = StrbW'(8'h0F);
        base_wdata = DATA_W'(in_wdata[31:0]);
      end
      default: begin
        size_mask  = OffW'(7);
        base_mask  = StrbW'(8'hFF);
        base_wdata = in_wdata;
      end
    endcase
    lane_off = in_off & ~size_mask;
    st_mask  = base_mask << lane_off;
    st_wdata = base_wdata << {lane_off, 3'b000};
    illegal  = (in_funct3 == 3'b111) ||
               ((DATA_W == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));
`ifdef YSYX_23060111_LSU_MISALIGN_TRAP_EN
    misaligned = |(in_off & size_mask);
    trap       = illegal || misaligned;
`else
    trap       = illegal;
`endif
  end

  // Load extraction from the captured lane offset.
  always_comb begin
    shifted = mem_rsp_data >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = DATA_W'($signed(shifted[7:0]));
      3'b001:  ld_data = DATA_W'($signed(shifted[15:0]));
      3'b010:  ld_data = DATA_W'($signed(shifted[31:0]));
      3'b011:  ld_data = shifted;
      3'b100:  ld_data = DATA_W'(shifted[7:0]);
      3'b101:  ld_data = DATA_W'(shifted[15:0]);
      3'b110:  ld_data = DATA_W'(shifted[31:0]);
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    cnt_inc     = (cnt_q >= CntMax) ? cnt_q : cnt_q + 1'b1;
    timeout_hit = (cnt_q >= CntLast);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    off_d    = off_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          addr_d   = {in_addr[ADDR_W-1:OffW], {OffW{1'b0}}};
          wen_d    = in_wen && !trap;
          wdata_d  = in_wen ? st_wdata : '0;
          wmask_d  = (in_wen && !trap) ? st_mask : '0;
          off_d    = lane_off;
          funct3_d = in_funct3;
          cnt_d    = '0;
          rdata_d  = '0;
          err_d    = trap;
          state_d  = trap ? StDone : StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_inc;
        if (mem_req_ready) begin
          state_d = StWait;
        end else if (timeout_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        // A response on the timeout cycle still wins.
        if (mem_rsp_valid) begin
          state_d = StDone;
          rdata_d = wen_q ? '0 : ld_data;
        end else if (timeout_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      off_q    <= off_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign in_ready      = (state_q == StIdle) && !rst;
  assign out_valid     = (state_q == StDone);
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;
  assign mem_req_valid = (state_q == StReq);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_ysyx_23060111_lsu.sv
// Bench for ysyx_23060111_lsu: directed vector table, reset corner sequences, random accesses
// checked against a byte-level reference model.
module tb_ysyx_23060111_lsu;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_wen = 1'b0;
  logic [2:0]    in_funct3 = '0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_wdata = '0;
  logic          out_valid;
  logic [DW-1:0] out_rdata;
  logic          out_err;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;

  always #5 clk = ~clk;

  ysyx_23060111_lsu #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_wen        (in_wen),
    .in_funct3     (in_funct3),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .out_valid     (out_valid),
    .out_rdata     (out_rdata),
    .out_err       (out_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  typedef struct {
    string       name;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rsp;
    int          rdy;
    int          rsp_dly;
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mwdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  logic        r_done, r_req, r_wen, r_stable, r_pulse, r_ready_ok, r_err;
  logic [31:0] r_rdata, r_maddr, r_mwdata;
  logic [3:0]  r_mask;
  int          r_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string name, logic wen, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rsp, int rdy, int rsp_dly,
                              logic exp_req, logic [31:0] exp_maddr, logic [3:0] exp_mask,
                              logic [31:0] exp_mwdata, logic exp_err, logic [31:0] exp_rdata,
                              int exp_lat);
    vec_t v;
    v.name = name; v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rsp = rsp;
    v.rdy = rdy; v.rsp_dly = rsp_dly; v.exp_req = exp_req; v.exp_maddr = exp_maddr;
    v.exp_mask = exp_mask; v.exp_mwdata = exp_mwdata; v.exp_err = exp_err;
    v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Reference model: byte-by-byte view of the access with plain arithmetic.
  function automatic vec_t model(logic wen, logic [2:0] f3, logic [31:0] addr,
                                 logic [31:0] wdata, logic [31:0] rsp, int rdy, int rsp_dly);
    vec_t   v;
    int     size;
    int     lane;
    longint val;
    bit     illegal, mis, trap;
    v = mk("rand", wen, f3, addr, wdata, rsp, rdy, rsp_dly, 0, 0, 0, 0, 0, 0, 0);
    size    = 1 << f3[1:0];
    illegal = (f3 == 3'b111) || (f3 == 3'b011) || (f3 == 3'b110);
    mis     = (addr % size) != 0;
    trap    = illegal;
`ifdef YSYX_23060111_LSU_MISALIGN_TRAP_EN
    trap    = illegal || mis;
`endif
    v.exp_err = trap;
    v.exp_req = !trap;
    v.exp_lat = trap ? 1 : 3 + rdy + rsp_dly;
    if (!trap) begin
      lane        = int'((addr - addr % size) % 4);
      v.exp_maddr = addr - addr % 4;
      val         = 0;
      for (int i = 0; i < size; i++) begin
        if (wen) begin
          v.exp_mask[lane + i] = 1'b1;
          v.exp_mwdata[8 * (lane + i) +: 8] = wdata[8 * i +: 8];
        end else begin
          val = val | (longint'(rsp[8 * (lane + i) +: 8]) << (8 * i));
        end
      end
      if (!wen && !f3[2] && size < 4 && val[8 * size - 1])
        val = val - (longint'(1) << (8 * size));
      v.exp_rdata = wen ? 32'h0 : val[31:0];
    end
    return v;
  endfunction

  task automatic run_access(input vec_t v);
    int   rq;
    int   wt;
    logic hs;
    r_done = 0; r_req = 0; r_wen = 0; r_stable = 1; r_pulse = 0; r_err = 0;
    r_rdata = 0; r_maddr = 0; r_mwdata = 0; r_mask = 0; r_lat = 0;
    r_ready_ok = in_ready;
    rq = 0; wt = 0; hs = 0;
    in_valid = 1'b1; in_wen = v.wen; in_funct3 = v.f3; in_addr = v.addr; in_wdata = v.wdata;
    step();
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_funct3 = 3'($urandom);
    r_lat = 1;
    while (!r_done && r_lat <= 100) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = ~v.rsp;
      if (in_ready) r_ready_ok = 0;
      if (out_valid) begin
        r_done  = 1;
        r_err   = out_err;
        r_rdata = out_rdata;
      end else begin
        if (!hs) begin
          if (mem_req_valid) begin
            if (!r_req) begin
              r_req = 1; r_maddr = mem_addr; r_mask = mem_wmask;
              r_mwdata = mem_wdata; r_wen = mem_wen;
            end else if (mem_addr !== r_maddr || mem_wmask !== r_mask ||
                         mem_wdata !== r_mwdata || mem_wen !== r_wen) begin
              r_stable = 0;
            end
            if (rq == v.rdy) begin
              mem_req_ready = 1'b1;
              hs = 1;
            end else begin
              mem_rsp_valid = 1'b1;  // stray response before the handshake
            end
            rq++;
          end
        end else begin
          if (wt == v.rsp_dly) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = v.rsp;
          end
          wt++;
        end
        step();
        r_lat++;
      end
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    if (r_done) begin
      step();
      r_pulse = !out_valid && in_ready;
    end
  endtask

  task automatic apply(input vec_t v);
    logic [31:0] bm;
    run_access(v);
    check({v.name, ".done"}, r_done, 1);
    check({v.name, ".err"}, r_err, v.exp_err);
    check({v.name, ".rdata"}, r_rdata, v.exp_rdata);
    check({v.name, ".req"}, r_req, v.exp_req);
    if (v.exp_req) begin
      check({v.name, ".maddr"}, r_maddr, v.exp_maddr);
      check({v.name, ".mwen"}, r_wen, v.wen);
      check({v.name, ".stable"}, r_stable, 1);
      if (v.wen) begin
        bm = '0;
        for (int i = 0; i < 4; i++) if (v.exp_mask[i]) bm[8 * i +: 8] = 8'hFF;
        check({v.name, ".wmask"}, r_mask, v.exp_mask);
        check({v.name, ".wdata"}, r_mwdata & bm, v.exp_mwdata);
      end
    end
    check({v.name, ".latency"}, r_lat, v.exp_lat);
    check({v.name, ".pulse"}, r_pulse, 1);
    check({v.name, ".ready"}, r_ready_ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    // Reset state
    step();
    step();
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_err", out_err, 0);
    check("rst.out_rdata", out_rdata, 0);
    check("rst.mem_req_valid", mem_req_valid, 0);
    check("rst.mem_wen", mem_wen, 0);
    check("rst.mem_wmask", mem_wmask, 0);
    rst = 1'b0;
    #1;
    check("rst.in_ready_after", in_ready, 1);

    vecs.push_back(mk("sb_lane1", 1, 3'b000, 32'h8000_0041, 32'h0000_00AB, 32'h0, 0, 0,
                      1, 32'h8000_0040, 4'b0010, 32'h0000_AB00, 0, 32'h0, 3));
    vecs.push_back(mk("sb_lane3", 1, 3'b000, 32'h8000_0103, 32'hFFFF_FF5A, 32'h0, 0, 0,
                      1, 32'h8000_0100, 4'b1000, 32'h5A00_0000, 0, 32'h0, 3));
    vecs.push_back(mk("lb_sext", 0, 3'b000, 32'h8000_0043, 32'h0, 32'h80FF_1234, 0, 0,
                      1, 32'h8000_0040, 4'h0, 32'h0, 0, 32'hFFFF_FF80, 3));
    vecs.push_back(mk("lbu_zext", 0, 3'b100, 32'h8000_0043, 32'h0, 32'h80FF_1234, 0, 0,
                      1, 32'h8000_0040, 4'h0, 32'h0, 0, 32'h0000_0080, 3));
    vecs.push_back(mk("lw_stall", 0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 5, 1,
                      1, 32'h8000_0010, 4'h0, 32'h0, 0, 32'hDEAD_BEEF, 9));
`ifdef YSYX_23060111_LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("lw_misaligned", 0, 3'b010, 32'h8000_0002, 32'h0, 32'h1122_3344, 0, 0,
                      0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1));
`else
    vecs.push_back(mk("lw_misaligned", 0, 3'b010, 32'h8000_0002, 32'h0, 32'h1122_3344, 0, 0,
                      1, 32'h8000_0000, 4'h0, 32'h0, 0, 32'h1122_3344, 3));
`endif
    vecs.push_back(mk("ld_illegal", 0, 3'b011, 32'h8000_0008, 32'h0, 32'h55, 0, 0,
                      0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk("f3_111", 1, 3'b111, 32'h8000_0000, 32'h1234, 32'h0, 0, 0,
                      0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk("lwu_illegal", 0, 3'b110, 32'h8000_0004, 32'h0, 32'h77, 0, 0,
                      0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk("tmo_wait", 0, 3'b001, 32'h8000_0006, 32'h0, 32'h8001_7FFF, 0, -1,
                      1, 32'h8000_0004, 4'h0, 32'h0, 1, 32'h0, TO + 1));
    vecs.push_back(mk("tmo_req", 0, 3'b010, 32'h8000_0020, 32'h0, 32'h0, 1000, 0,
                      1, 32'h8000_0020, 4'h0, 32'h0, 1, 32'h0, TO + 1));
    vecs.push_back(mk("tmo_edge", 0, 3'b001, 32'h8000_0006, 32'h0, 32'h8001_7FFF, 0, TO - 2,
                      1, 32'h8000_0004, 4'h0, 32'h0, 0, 32'hFFFF_8001, TO + 1));
    vecs.push_back(mk("tmo_edge_rdy", 0, 3'b010, 32'h8000_0008, 32'h0, 32'h0BAD_F00D, 3, TO - 5,
                      1, 32'h8000_0008, 4'h0, 32'h0, 0, 32'h0BAD_F00D, TO + 1));
    vecs.push_back(mk("sh_lane2", 1, 3'b001, 32'h8000_0002, 32'h1234_5678, 32'h0, 0, 0,
                      1, 32'h8000_0000, 4'b1100, 32'h5678_0000, 0, 32'h0, 3));
    vecs.push_back(mk("sw", 1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 32'h0, 1, 2,
                      1, 32'h8000_0004, 4'b1111, 32'hCAFE_F00D, 0, 32'h0, 6));
    vecs.push_back(mk("lhu_lane2", 0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 0, 0,
                      1, 32'h8000_0000, 4'h0, 32'h0, 0, 32'h0000_8001, 3));
    vecs.push_back(mk("lh_pos", 0, 3'b001, 32'h8000_0000, 32'h0, 32'h8001_7FFF, 0, 0,
                      1, 32'h8000_0000, 4'h0, 32'h0, 0, 32'h0000_7FFF, 3));
    foreach (vecs[i]) apply(vecs[i]);

    // Reset while waiting for the response; a late response must be ignored.
    in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b010; in_addr = 32'h8000_0030;
    step();
    in_valid = 1'b0;
    check("rstwait.req", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("rstwait.in_wait", mem_req_valid, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234_5678;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen = 1;
      step();
    end
    mem_rsp_valid = 1'b0;
    check("rstwait.no_out_valid", seen, 0);
    check("rstwait.in_ready", in_ready, 1);
    check("rstwait.mem_req_valid", mem_req_valid, 0);

    // Reset while the request is outstanding.
    in_valid = 1'b1; in_wen = 1'b1; in_funct3 = 3'b010; in_addr = 32'h8000_0040;
    in_wdata = 32'hA5A5_A5A5;
    step();
    in_valid = 1'b0;
    check("rstreq.req", mem_req_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstreq.mem_req_valid", mem_req_valid, 0);
    check("rstreq.mem_wmask", mem_wmask, 0);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid) seen = 1;
      step();
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    check("rstreq.no_out_valid", seen, 0);
    check("rstreq.in_ready", in_ready, 1);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3;
      logic [2:0] legal [5];
      vec_t       v;
      legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010; legal[3] = 3'b100;
      legal[4] = 3'b101;
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = legal[$urandom_range(0, 4)];
      v = model(1'($urandom), f3, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      v.name = $sformatf("rand%0d", n);
      apply(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060111_lsu.md
YSYX_23060111_LSU -- requirements
Module: ysyx_23060111_lsu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, response-wait cycle limit; range 1..65535.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1  core access request valid.
REQ-007 SHALL have port in_ready  out  1  LSU can accept a request.
REQ-008 SHALL have port in_wen  in  1  1 = store, 0 = load.
REQ-009 SHALL have port in_funct3  in  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-010 SHALL have port in_addr  in  ADDR_W  byte address.
REQ-011 SHALL have port in_wdata  in  DATA_W  store data, LSB-aligned.
REQ-012 SHALL have port out_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port out_rdata  out  DATA_W  extended load data; zero for stores.
REQ-014 SHALL have port out_err  out  1  error flag, valid with out_valid.
REQ-015 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_addr out ADDR_W (aligned down to DATA_W/8), mem_wen out 1, mem_wdata out DATA_W, mem_wmask out DATA_W/8.
REQ-016 SHALL have ports mem_rsp_valid in 1, mem_rsp_data in DATA_W.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; request accepted when in_valid && in_ready; all inputs registered on acceptance.
REQ-019 IDLE -> REQ on acceptance; REQ drives mem_req_valid=1 and holds all mem_* stable until mem_req_ready=1, then -> WAIT.
REQ-020 WAIT -> DONE on mem_rsp_valid; load data captured that cycle; mem_rsp_valid outside WAIT SHALL be ignored.
REQ-021 DONE SHALL assert out_valid for exactly one cycle, then -> IDLE; minimum latency acceptance-to-out_valid is 3 cycles.
REQ-022 Store: mem_wdata = in_wdata replicated/shifted to byte lane addr[log2(DATA_W/8)-1:0]; mem_wmask = 1, 3, F or FF (by width) shifted by the same offset.
REQ-023 Load: byte lane extracted by offset; sign-extended for B/H/W, zero-extended for BU/HU/WU; D passes full word.
REQ-024 funct3 011/110 with DATA_W=32, or 111 in any case, SHALL be illegal: no memory request, FSM IDLE -> DONE, out_err=1, out_rdata=0.
REQ-025 A cycle counter SHALL run in REQ and WAIT, clear on entry to REQ; on reaching TIMEOUT without completion, -> DONE with out_err=1, out_rdata=0; counter saturates, never wraps.
REQ-026 An access whose response arrives in the same cycle the counter reaches TIMEOUT SHALL complete normally (out_err=0).

Reset
REQ-027 While rst=1 at a clock edge: FSM -> IDLE, counter=0, in_ready=0 during reset cycle then 1, out_valid=0, out_err=0, out_rdata=0, mem_req_valid=0, mem_wen=0, mem_wmask=0.
REQ-028 Reset asserted mid-access (REQ or WAIT) SHALL abandon it with no out_valid; later stray mem_rsp_valid is ignored.

Configuration
REQ-029 Macro YSYX_23060111_LSU_MISALIGN_TRAP_EN defined: H/W/D access with addr not a multiple of its size SHALL issue no memory request and complete via DONE with out_err=1.
REQ-030 Macro undefined: misaligned accesses SHALL issue a request with addr aligned down to the access size (low bits dropped), out_err=0.

Verification
REQ-031 DATA_W=32, store SB addr 0x80000041 wdata 0xAB -> mem_addr 0x80000040, mem_wmask 0b0010, mem_wdata 0x0000AB00.
REQ-032 Load LB addr 0x80000043, mem_rsp_data 0x80FF_1234 -> out_rdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-033 mem_req_ready held 0 for 5 cycles, rsp 2 cycles later -> mem_* stable throughout, out_valid one cycle, latency 9 cycles.
REQ-034 TIMEOUT=4, no mem_rsp_valid -> out_valid with out_err=1 exactly 4 cycles after entering REQ, in_ready=1 next cycle.
REQ-035 LW addr 0x80000002 -> with macro: out_err=1, no mem_req_valid; without: mem_addr 0x80000000, out_err=0.
REQ-036 rst pulsed in WAIT, then mem_rsp_valid=1 -> no out_valid, state IDLE, in_ready=1.
